// File: rtl/timer_pkg.sv
// ============================================================================
//  timer_pkg : shared types, unit constants and tick computation for timer_core
//  Revision  : 1.0
// ============================================================================
`default_nettype none

package timer_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RUNNING = 1'b1
  } timer_state_t;

  localparam longint unsigned UNIT_NS_NS = 64'd1;
  localparam longint unsigned UNIT_NS_US = 64'd1_000;
  localparam longint unsigned UNIT_NS_MS = 64'd1_000_000;
  localparam longint unsigned UNIT_NS_S  = 64'd1_000_000_000;

  // Unit strings arrive zero-extended to 32 bits; an unknown unit maps to 0.
  function automatic longint unsigned unit_ns(input logic [31:0] unit);
    case (unit)
      32'("ns"): unit_ns = UNIT_NS_NS;
      32'("us"): unit_ns = UNIT_NS_US;
      32'("ms"): unit_ns = UNIT_NS_MS;
      32'("s"):  unit_ns = UNIT_NS_S;
      default:   unit_ns = 64'd0;
    endcase
  endfunction

  function automatic longint unsigned calc_ticks(input longint unsigned clk_ns,
                                                 input longint unsigned period,
                                                 input logic [31:0]     unit);
    longint unsigned ticks;
    ticks = (period * unit_ns(unit)) / clk_ns;
    if (ticks < 64'd1) ticks = 64'd1;
    return ticks;
  endfunction

endpackage

`default_nettype wire

// File: rtl/timer_downcounter.sv
// ============================================================================
//  timer_downcounter : loadable, enable-qualified down-counter that holds at 0
//  Revision          : 1.0
// ============================================================================
`default_nettype none

module timer_downcounter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/timer_core.sv
// ============================================================================
//  timer_core : one-shot interval timer with registered done pulse and busy.
//  Optional macro TIMER_AUTORELOAD_EN turns it into a periodic timer.
//  Revision   : 1.0
// ============================================================================
`default_nettype none

module timer_core
  import timer_pkg::*;
#(
  parameter int CLK_PERIOD_ns     = 20,
  parameter int TIMER_PERIOD_ms   = 30,
  parameter     TIMER_PERIOD_TYPE = "ms"
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic start,
  output logic done,
  output logic busy
);

  localparam logic [31:0]     C_UNIT   = 32'(TIMER_PERIOD_TYPE);
  localparam longint unsigned C_N      = calc_ticks(64'(CLK_PERIOD_ns), 64'(TIMER_PERIOD_ms), C_UNIT);
  localparam int              C_CW     = $clog2(C_N + 1);
  localparam logic [C_CW-1:0] C_RELOAD = C_CW'(C_N - 1);

  if (unit_ns(C_UNIT) == 64'd0) begin : g_bad_unit
    $error("timer_core: TIMER_PERIOD_TYPE must be \"ns\", \"us\", \"ms\" or \"s\"");
  end

  timer_state_t r_state;
  timer_state_t w_next_state;
  logic         w_load;
  logic         w_done_next;
  logic         w_zero;

  timer_downcounter #(
    .WIDTH (C_CW)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .en       (enable && (r_state == RUNNING)),
    .load     (w_load),
    .load_val (C_RELOAD),
    .zero     (w_zero)
  );

  // A start seen while running always reloads, even on the expiry cycle.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_done_next  = 1'b0;
    if (enable) begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_load       = 1'b1;
            w_next_state = RUNNING;
          end
        end
        RUNNING: begin
          if (start) begin
            w_load = 1'b1;
          end else if (w_zero) begin
            w_done_next = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
            w_load       = 1'b1;
`else
            w_next_state = IDLE;
`endif
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      done    <= w_done_next;
      busy    <= (w_next_state == RUNNING);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_timer_core.sv
// ============================================================================
//  tb_timer_core : randomized + directed bench for timer_core against an
//  interval-level reference model (two instances: N=100 and N=1).
//  Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_timer_core;

  logic clk = 1'b0;
  logic reset, enable, start;
  logic done, busy, done1, busy1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state per instance: armed flag and edges remaining until done.
  int m_n [2] = '{100, 1};
  bit m_armed [2];
  int m_rem [2];
  bit m_done [2];

  always #5 clk = ~clk;

  timer_core #(
    .CLK_PERIOD_ns     (20),
    .TIMER_PERIOD_ms   (2),
    .TIMER_PERIOD_TYPE ("us")
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .start  (start),
    .done   (done),
    .busy   (busy)
  );

  timer_core #(
    .CLK_PERIOD_ns     (20),
    .TIMER_PERIOD_ms   (20),
    .TIMER_PERIOD_TYPE ("ns")
  ) dut1 (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .start  (start),
    .done   (done1),
    .busy   (busy1)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 1'b0;
      if (reset) begin
        m_armed[k] = 1'b0;
        m_rem[k]   = 0;
      end else if (enable) begin
        if (start) begin
          m_armed[k] = 1'b1;
          m_rem[k]   = m_n[k];
        end else if (m_armed[k]) begin
          m_rem[k]--;
          if (m_rem[k] == 0) begin
            m_done[k] = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
            m_rem[k] = m_n[k];
`else
            m_armed[k] = 1'b0;
`endif
          end
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("done_n100", done,  m_done[0]);
    check("busy_n100", busy,  m_armed[0]);
    check("done_n1",   done1, m_done[1]);
    check("busy_n1",   busy1, m_armed[1]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic run_until_done(input int bound, output int cyc);
    cyc = bound + 1;
    for (int i = 1; i <= bound; i++) begin
      step();
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    int c;
    int cnt;
    reset = 1'b1; enable = 1'b1; start = 1'b0;
    do_reset();
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);

    // Basic interval: done 100 edges after start, busy in between.
    pulse_start();
    check("busy_after_start", busy, 1);
    run_until_done(200, c);
    check("latency_basic", c, 100);
`ifndef TIMER_AUTORELOAD_EN
    check("busy_after_done", busy, 0);
    step();
    check("done_one_cycle", done, 0);
`endif
    do_reset();

    // Enable dropped for 37 cycles mid-count.
    pulse_start();
    repeat (50) step();
    enable = 1'b0;
    repeat (37) step();
    check("busy_while_frozen", busy, 1);
    enable = 1'b1;
    run_until_done(200, c);
    check("latency_freeze", c + 87, 137);
    do_reset();

    // Restart 40 cycles after the first start.
    pulse_start();
    repeat (39) step();
    pulse_start();
    run_until_done(200, c);
    check("latency_restart", c + 40, 140);
    do_reset();

    // Start coinciding with expiry: no done, full new interval.
    pulse_start();
    repeat (99) step();
    pulse_start();
    check("no_done_on_restart", done, 0);
    run_until_done(200, c);
    check("latency_expiry_restart", c, 100);
    do_reset();

    // Reset mid-count cancels the interval.
    pulse_start();
    repeat (59) step();
    reset = 1'b1;
    step();
    check("reset_mid_busy", busy, 0);
    check("reset_mid_done", done, 0);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (done) cnt++;
    end
    check("no_done_after_reset", cnt, 0);

`ifdef TIMER_AUTORELOAD_EN
    // Periodic pulses every N cycles.
    pulse_start();
    for (int p = 1; p <= 3; p++) begin
      run_until_done(200, c);
      check("autoreload_period", c, 100);
    end
    do_reset();
`endif

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      reset  = ($urandom_range(0, 499) == 0);
      enable = ($urandom_range(0, 7) != 0);
      start  = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
